addsub_checker: RTL and testbench

ADDSUB_CHECKER -- requirements
Module: addsub_checker

---
 rtl/addsub_checker_pkg.sv | 22 ++
 rtl/addsub_ref.sv | 16 +
 rtl/addsub_checker.sv | 120 ++++++++++++
 tb/tb_addsub_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_checker_pkg.sv
// rtl/addsub_checker_pkg.sv - shared types, defaults and golden response for addsub_checker
package addsub_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_VEC_DEFAULT = 16;

  // Returns {fa, ha, fs, hs}, each {carry/borrow, sum/diff}.
  function automatic logic [7:0] expected_resp(input logic a, input logic b, input logic c);
    logic [1:0] fa_e, ha_e, fs_e, hs_e;
    fa_e = {1'b0, a} + {1'b0, b} + {1'b0, c};
    ha_e = {1'b0, a} + {1'b0, b};
    fs_e = {(~a & (b | c)) | (b & c), a ^ b ^ c};
    hs_e = {~a & b, a ^ b};
    return {fa_e, ha_e, fs_e, hs_e};
  endfunction

endpackage

// File: rtl/addsub_ref.sv
// rtl/addsub_ref.sv - combinational reference adder/subtractor responses
module addsub_ref
  import addsub_checker_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  output logic [1:0] fa_o,
  output logic [1:0] ha_o,
  output logic [1:0] fs_o,
  output logic [1:0] hs_o
);

  assign {fa_o, ha_o, fs_o, hs_o} = expected_resp(a_i, b_i, c_i);

endmodule

// File: rtl/addsub_checker.sv
// rtl/addsub_checker.sv - two-stage checker for a 1-bit adder/subtractor under test
module addsub_checker
  import addsub_checker_pkg::*;
#(
  parameter int unsigned MAX_VEC = MAX_VEC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vec_valid,
  input  logic       vec_a,
  input  logic       vec_b,
  input  logic       vec_c,
  input  logic [1:0] fa,
  input  logic [1:0] ha,
  input  logic [1:0] fs,
  input  logic [1:0] hs,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] cov_mask,
  output logic [3:0] first_fail
);

  state_e     state_q, state_d;
  logic       s1_valid_q, s1_valid_d;
  logic [2:0] s1_abc_q, s1_abc_d;
  logic [7:0] s1_resp_q, s1_resp_d;
  logic [7:0] err_q, err_d;
  logic [7:0] cov_q, cov_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] ff_q, ff_d;

  logic [1:0] ref_fa, ref_ha, ref_fs, ref_hs;
  logic [7:0] cov_upd, cnt_upd;
  logic       mismatch, finish;

  addsub_ref u_ref (
    .a_i  (s1_abc_q[2]),
    .b_i  (s1_abc_q[1]),
    .c_i  (s1_abc_q[0]),
    .fa_o (ref_fa),
    .ha_o (ref_ha),
    .fs_o (ref_fs),
    .hs_o (ref_hs)
  );

  assign mismatch = s1_resp_q != {ref_fa, ref_ha, ref_fs, ref_hs};
  assign cov_upd  = cov_q | (8'd1 << s1_abc_q);
  assign cnt_upd  = cnt_q + 8'd1;
  // Termination is judged on the post-update values so the completing vector itself ends the run.
  assign finish   = (state_q == ST_RUN) && s1_valid_q &&
                    ((cov_upd == 8'hFF) || (cnt_upd == 8'(MAX_VEC)));

  always_comb begin
    state_d    = state_q;
    s1_valid_d = 1'b0;
    s1_abc_d   = {vec_a, vec_b, vec_c};
    s1_resp_d  = {fa, ha, fs, hs};
    err_d      = err_q;
    cov_d      = cov_q;
    cnt_d      = cnt_q;
    ff_d       = ff_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          err_d   = 8'd0;
          cov_d   = 8'd0;
          cnt_d   = 8'd0;
          ff_d    = 4'd0;
        end
      end
      ST_RUN: begin
        if (s1_valid_q) begin
          cnt_d = cnt_upd;
          cov_d = cov_upd;
          if (mismatch) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (!ff_q[3])       ff_d  = {1'b1, s1_abc_q};
          end
        end
        if (finish) state_d    = ST_DONE;
        else        s1_valid_d = vec_valid;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      s1_valid_q <= 1'b0;
      s1_abc_q   <= 3'd0;
      s1_resp_q  <= 8'd0;
      err_q      <= 8'd0;
      cov_q      <= 8'd0;
      cnt_q      <= 8'd0;
      ff_q       <= 4'd0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_abc_q   <= s1_abc_d;
      s1_resp_q  <= s1_resp_d;
      err_q      <= err_d;
      cov_q      <= cov_d;
      cnt_q      <= cnt_d;
      ff_q       <= ff_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_q == 8'd0) && (cov_q == 8'hFF);
  assign err_count  = err_q;
  assign cov_mask   = cov_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_addsub_checker.sv
// tb/tb_addsub_checker.sv - directed self-checking bench for addsub_checker
module tb_addsub_checker;

  localparam int MAXV = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vec_valid = 1'b0;
  logic       vec_a = 1'b0, vec_b = 1'b0, vec_c = 1'b0;
  logic [1:0] fa = 2'd0, ha = 2'd0, fs = 2'd0, hs = 2'd0;
  logic       busy, done, pass;
  logic [7:0] err_count, cov_mask;
  logic [3:0] first_fail;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  addsub_checker #(.MAX_VEC(MAXV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vec_valid  (vec_valid),
    .vec_a      (vec_a),
    .vec_b      (vec_b),
    .vec_c      (vec_c),
    .fa         (fa),
    .ha         (ha),
    .fs         (fs),
    .hs         (hs),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .cov_mask   (cov_mask),
    .first_fail (first_fail)
  );

  // Correct responses from plain integer add/subtract; borrow is a negative result.
  function automatic logic [7:0] golden(input logic [2:0] v);
    int a, b, c, s, h, d, e;
    logic [7:0] r;
    a = int'(v[2]);
    b = int'(v[1]);
    c = int'(v[0]);
    s = a + b + c;
    h = a + b;
    d = a - b - c;
    e = a - b;
    r[7:6] = 2'(s);
    r[5:4] = 2'(h);
    r[3:2] = {d < 0, d[0]};
    r[1:0] = {e < 0, e[0]};
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic       m_run = 1'b0, m_done = 1'b0, m_pend = 1'b0;
  logic [2:0] m_pv = 3'd0;
  logic [7:0] m_pr = 8'd0;
  logic [7:0] m_cov = 8'd0;
  logic [3:0] m_ff = 4'd0;
  int         m_err = 0, m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] cov_n;
    logic [3:0] ff_n;
    int         cnt_n, err_n;
    logic       fin;
    if (!rst_n) begin
      m_run <= 1'b0; m_done <= 1'b0; m_pend <= 1'b0;
      m_err <= 0; m_cnt <= 0; m_cov <= 8'd0; m_ff <= 4'd0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1'b1; m_done <= 1'b0; m_pend <= 1'b0;
        m_err <= 0; m_cnt <= 0; m_cov <= 8'd0; m_ff <= 4'd0;
      end
    end else begin
      cov_n = m_cov; ff_n = m_ff; cnt_n = m_cnt; err_n = m_err;
      if (m_pend) begin
        cnt_n = cnt_n + 1;
        cov_n[m_pv] = 1'b1;
        if (m_pr != golden(m_pv)) begin
          err_n = (err_n < 255) ? err_n + 1 : 255;
          if (ff_n == 4'd0) ff_n = {1'b1, m_pv};
        end
      end
      fin = m_pend && (cov_n == 8'hFF || cnt_n == MAXV);
      m_cov <= cov_n; m_ff <= ff_n; m_cnt <= cnt_n; m_err <= err_n;
      m_pend <= vec_valid && !fin;
      m_pv <= {vec_a, vec_b, vec_c};
      m_pr <= {fa, ha, fs, hs};
      if (fin) begin
        m_run <= 1'b0;
        m_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_busy", int'(busy), int'(m_run));
      chk("cyc_done", int'(done), int'(m_done));
      chk("cyc_pass", int'(pass), int'(m_done && m_err == 0 && m_cov == 8'hFF));
      chk("cyc_err", int'(err_count), m_err);
      chk("cyc_cov", int'(cov_mask), int'(m_cov));
      chk("cyc_first_fail", int'(first_fail), int'(m_ff));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] v, input logic [7:0] corrupt, input logic st);
    {vec_a, vec_b, vec_c} = v;
    {fa, ha, fs, hs} = golden(v) ^ corrupt;
    vec_valid = 1'b1;
    start = st;
    tick();
    vec_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Scenario 1: all 8 vectors, correct responses
    pulse_start();
    chk("s1_busy_after_start", int'(busy), 1);
    for (int v = 0; v < 8; v++) send(3'(v), 8'h00, 1'b0);
    chk("s1_busy_one_after_last", int'(busy), 1);
    chk("s1_done_one_after_last", int'(done), 0);
    tick();
    chk("s1_done", int'(done), 1);
    chk("s1_pass", int'(pass), 1);
    chk("s1_err", int'(err_count), 0);
    chk("s1_cov", int'(cov_mask), 8'hFF);
    chk("s1_model_cov", int'(m_cov), 8'hFF);

    // Scenario 2: restart from DONE, vector 011 with fs forced to 00
    pulse_start();
    chk("s2_busy", int'(busy), 1);
    chk("s2_err_cleared", int'(err_count), 0);
    chk("s2_cov_cleared", int'(cov_mask), 0);
    for (int v = 0; v < 8; v++) send(3'(v), (v == 3) ? 8'h08 : 8'h00, 1'b0);
    tick();
    chk("s2_done", int'(done), 1);
    chk("s2_err", int'(err_count), 1);
    chk("s2_first_fail", int'(first_fail), 4'b1011);
    chk("s2_pass", int'(pass), 0);
    chk("s2_model_ff", int'(m_ff), 4'b1011);

    // Scenario 3: vector 000 sixteen times hits MAX_VEC
    pulse_start();
    repeat (MAXV) send(3'd0, 8'h00, 1'b0);
    chk("s3_busy_before_limit", int'(busy), 1);
    tick();
    chk("s3_done", int'(done), 1);
    chk("s3_cov", int'(cov_mask), 8'h01);
    chk("s3_pass", int'(pass), 0);
    chk("s3_err", int'(err_count), 0);

    // Scenario 4: asynchronous reset mid-run
    pulse_start();
    send(3'd0, 8'h00, 1'b0);
    send(3'd1, 8'h80, 1'b0);
    send(3'd2, 8'h00, 1'b0);
    send(3'd3, 8'h00, 1'b0);
    chk("s4_err_before_reset", int'(err_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s4_busy", int'(busy), 0);
    chk("s4_done", int'(done), 0);
    chk("s4_pass", int'(pass), 0);
    chk("s4_err", int'(err_count), 0);
    chk("s4_cov", int'(cov_mask), 0);
    chk("s4_first_fail", int'(first_fail), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("s4_idle_busy", int'(busy), 0);
    chk("s4_idle_done", int'(done), 0);

    // Scenario 5: vec_valid in IDLE, start pulse during RUN
    repeat (3) send(3'd5, 8'hFF, 1'b0);
    chk("s5_idle_err", int'(err_count), 0);
    chk("s5_idle_cov", int'(cov_mask), 0);
    chk("s5_idle_busy", int'(busy), 0);
    pulse_start();
    send(3'd1, 8'h00, 1'b0);
    send(3'd2, 8'h10, 1'b0);
    send(3'd4, 8'h00, 1'b1);
    send(3'd7, 8'h00, 1'b0);
    tick();
    chk("s5_busy", int'(busy), 1);
    chk("s5_err", int'(err_count), 1);
    chk("s5_cov", int'(cov_mask), 8'h96);
    chk("s5_first_fail", int'(first_fail), 4'b1010);
    chk("s5_model_err", m_err, 1);

    // Scenario 6: ninth vector in flight when coverage completes is dropped
    do_reset();
    pulse_start();
    for (int v = 0; v < 8; v++) send(3'(v), 8'h00, 1'b0);
    send(3'd0, 8'hFF, 1'b0);
    chk("s6_done", int'(done), 1);
    chk("s6_err", int'(err_count), 0);
    chk("s6_pass", int'(pass), 1);
    send(3'd3, 8'hFF, 1'b0);
    send(3'd6, 8'hFF, 1'b0);
    tick();
    chk("s6_done_hold", int'(done), 1);
    chk("s6_err_hold", int'(err_count), 0);
    chk("s6_pass_hold", int'(pass), 1);
    chk("s6_model_cnt", m_cnt, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
